// File: rtl/shift_serializer_if.sv
// Handshake bundle for the shift serializer.
// The load side carries a parallel vector in. The out side streams it back out one word per beat.
interface shift_serializer_if #(
  parameter int size       = 3,
  parameter int data_width = 32
);
  logic                  load_valid;
  logic                  load_ready;
  logic [data_width-1:0] data_in [size-1:0];
  logic                  three_shift;
  logic                  out_valid;
  logic                  out_ready;
  logic [data_width-1:0] out_data;
  logic                  out_last;

  // Producer/consumer side, as seen by whoever feeds and drains the block
  modport master (
    output load_valid, data_in, three_shift, out_ready,
    input  load_ready, out_valid, out_data, out_last
  );

  // Serializer side
  modport slave (
    input  load_valid, data_in, three_shift, out_ready,
    output load_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/shift_serializer.sv
// Parallel-in, serial-out unloader for the convolver datapath.
// Words leave highest index first, so a size-deep shift register fed one word per beat
// rebuilds the vector in its original order. Stride 3 emits every third word for strided convolution.
module shift_serializer #(
  parameter int size       = 3,
  parameter int data_width = 32
) (
  input  logic               clock,
  input  logic               reset,
  shift_serializer_if.slave  bus
);
  // The pointer must reach -3 after the last stride-3 step, so it needs one extra sign bit.
  localparam int PW = $clog2(size + 3) + 1;
  localparam int IW = (size > 1) ? $clog2(size) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state, state_nxt;
  logic [data_width-1:0]  arr [size-1:0];
  logic signed [PW-1:0]   ptr, ptr_dec, stride;
  logic                   three;
  logic                   last, beat, load_fire;
  logic [IW-1:0]          idx;

  assign stride    = three ? PW'(3) : PW'(1);
  assign ptr_dec   = ptr - stride;
  assign idx       = ptr[IW-1:0];
  assign load_fire = bus.load_valid & bus.load_ready;
  assign beat      = bus.out_valid & bus.out_ready;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and output decode. out_* come from registered state only.
  // load_ready alone looks at out_ready, so that a new vector can overlap the last beat.
  always_comb begin
    state_nxt      = state;
    bus.out_valid  = 1'b0;
    bus.out_last   = 1'b0;
    bus.out_data   = '0;
    bus.load_ready = 1'b0;
    last           = 1'b0;
    case (state)
      IDLE: begin
        bus.load_ready = 1'b1;
        if (bus.load_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        bus.out_valid  = 1'b1;
        bus.out_data   = arr[idx];
        // The sign bit of the stepped pointer shows that no further word is in range.
        last           = ptr_dec[PW-1];
        bus.out_last   = last;
        bus.load_ready = bus.out_ready & last;
        if (bus.out_ready && last && !bus.load_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Vector capture and pointer stepping. A load takes priority over the final step.
  // An accepted load always coincides with either IDLE or the last beat.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < size; i++) arr[i] <= '0;
      ptr   <= '0;
      three <= 1'b0;
    end else if (load_fire) begin
      for (int i = 0; i < size; i++) arr[i] <= bus.data_in[i];
      ptr   <= PW'(size - 1);
      three <= bus.three_shift;
    end else if (beat && !last) begin
      ptr <= ptr_dec;
    end
  end
endmodule

// File: tb/tb_shift_serializer.sv
// Directed bench for shift_serializer.
// A size-3 instance covers stride 1, backpressure, back-to-back loads, reset and round-trip.
// A size-5 instance covers stride 3.
module tb_shift_serializer;
  logic clk, rst;
  int   n_cmp = 0;
  int   n_err = 0;

  localparam logic [31:0] A = 32'hA000_000A, B = 32'hB000_000B, C = 32'hC000_000C;
  localparam logic [31:0] D = 32'hD000_000D, E = 32'hE000_000E, F = 32'hF000_000F;

  shift_serializer_if #(.size(3), .data_width(32)) b3 ();
  shift_serializer_if #(.size(5), .data_width(32)) b5 ();

  shift_serializer #(.size(3), .data_width(32)) dut3 (.clock(clk), .reset(rst), .bus(b3.slave));
  shift_serializer #(.size(5), .data_width(32)) dut5 (.clock(clk), .reset(rst), .bus(b5.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream line register: one shift per accepted beat, new word enters at index 0
  logic [2:0][31:0] sr = '0;
  always @(posedge clk)
    if (b3.out_valid && b3.out_ready) sr <= {sr[1:0], b3.out_data};

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic exp3(input string tag, input logic v, input logic [31:0] d, input logic l);
    chk($sformatf("%s valid", tag), 64'(b3.out_valid), 64'(v));
    chk($sformatf("%s data", tag),  64'(b3.out_data),  64'(d));
    chk($sformatf("%s last", tag),  64'(b3.out_last),  64'(l));
  endtask

  task automatic exp5(input string tag, input logic v, input logic [31:0] d, input logic l);
    chk($sformatf("%s valid", tag), 64'(b5.out_valid), 64'(v));
    chk($sformatf("%s data", tag),  64'(b5.out_data),  64'(d));
    chk($sformatf("%s last", tag),  64'(b5.out_last),  64'(l));
  endtask

  task automatic load3(input logic [31:0] d0, d1, d2, input logic ts);
    b3.data_in[0]  = d0;
    b3.data_in[1]  = d1;
    b3.data_in[2]  = d2;
    b3.three_shift = ts;
    b3.load_valid  = 1'b1;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    b3.load_valid = 1'b0; b3.three_shift = 1'b0; b3.out_ready = 1'b0;
    b5.load_valid = 1'b0; b5.three_shift = 1'b0; b5.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) b3.data_in[i] = '0;
    for (int i = 0; i < 5; i++) b5.data_in[i] = '0;
    step(); step();

    // Reset state
    exp3("rst3", 1'b0, 32'h0, 1'b0);
    chk("rst3 load_ready", 64'(b3.load_ready), 64'd1);
    exp5("rst5", 1'b0, 32'h0, 1'b0);
    chk("rst5 load_ready", 64'(b5.load_ready), 64'd1);
    rst = 1'b0;

    // Stride 1: C, B, A
    b3.out_ready = 1'b1;
    load3(A, B, C, 1'b0);
    chk("s1 load_ready", 64'(b3.load_ready), 64'd1);
    step(); b3.load_valid = 1'b0;
    exp3("s1 w0", 1'b1, C, 1'b0);
    chk("s1 busy", 64'(b3.load_ready), 64'd0);
    step(); exp3("s1 w1", 1'b1, B, 1'b0);
    step(); exp3("s1 w2", 1'b1, A, 1'b1);
    chk("s1 last load_ready", 64'(b3.load_ready), 64'd1);
    step(); exp3("s1 idle", 1'b0, 32'h0, 1'b0);
    chk("rt word0", 64'(sr[0]), 64'(A));
    chk("rt word1", 64'(sr[1]), 64'(B));
    chk("rt word2", 64'(sr[2]), 64'(C));

    // Backpressure with a competing stride-3 load that must be ignored
    load3(A, B, C, 1'b0);
    step(); b3.load_valid = 1'b0;
    exp3("bp w0", 1'b1, C, 1'b0);
    b3.out_ready = 1'b0;
    load3(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      exp3($sformatf("bp hold%0d", i), 1'b1, C, 1'b0);
      chk($sformatf("bp hold%0d load_ready", i), 64'(b3.load_ready), 64'd0);
    end
    b3.load_valid = 1'b0;
    b3.out_ready  = 1'b1;
    step(); exp3("bp w1", 1'b1, B, 1'b0);
    step(); exp3("bp w2", 1'b1, A, 1'b1);
    step(); exp3("bp idle", 1'b0, 32'h0, 1'b0);

    // Back-to-back: the second vector is loaded during A's beat, with no bubble
    load3(A, B, C, 1'b0);
    step(); b3.load_valid = 1'b0;
    exp3("b2b w0", 1'b1, C, 1'b0);
    step(); exp3("b2b w1", 1'b1, B, 1'b0);
    step(); exp3("b2b w2", 1'b1, A, 1'b1);
    load3(D, E, F, 1'b0);
    chk("b2b overlap load_ready", 64'(b3.load_ready), 64'd1);
    step(); b3.load_valid = 1'b0;
    exp3("b2b w3", 1'b1, F, 1'b0);
    step(); exp3("b2b w4", 1'b1, E, 1'b0);
    step(); exp3("b2b w5", 1'b1, D, 1'b1);
    step(); exp3("b2b idle", 1'b0, 32'h0, 1'b0);

    // Reset after C is accepted: B and A never appear
    load3(A, B, C, 1'b0);
    step(); b3.load_valid = 1'b0;
    exp3("rm w0", 1'b1, C, 1'b0);
    step(); exp3("rm w1", 1'b1, B, 1'b0);
    rst = 1'b1; b3.out_ready = 1'b0;
    step();
    exp3("rm after", 1'b0, 32'h0, 1'b0);
    chk("rm load_ready", 64'(b3.load_ready), 64'd1);
    rst = 1'b0; b3.out_ready = 1'b1;
    step(); exp3("rm quiet0", 1'b0, 32'h0, 1'b0);
    step(); exp3("rm quiet1", 1'b0, 32'h0, 1'b0);

    // Stride 3 on size 5: index 4 then index 1. A mid-vector stride change is ignored.
    b5.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) b5.data_in[i] = 32'h10 + 32'(i);
    b5.three_shift = 1'b1;
    b5.load_valid  = 1'b1;
    step(); b5.load_valid = 1'b0; b5.three_shift = 1'b0;
    exp5("s3 w0", 1'b1, 32'h14, 1'b0);
    step(); exp5("s3 w1", 1'b1, 32'h11, 1'b1);
    step(); exp5("s3 idle", 1'b0, 32'h0, 1'b0);
    chk("s3 load_ready", 64'(b5.load_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/shift_serializer.md
# shift_serializer

Parallel-in, serial-out unloader for the convolver datapath; the inverse of the line shift register. It captures a `size`-word parallel vector in one handshake and streams it out one word per accepted beat with valid/ready flow control. Word order is chosen so that feeding its output into a `size`-deep shift register, one shift per beat, rebuilds the original vector. An optional three-stride mode emits every third word for strided convolution.

## Interface
- `size`, default 3: number of words per parallel vector, ≥1.
- `data_width`, default 32: bits per word.

- `clock`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-high; clears all state.
- `load_valid`  in  1: parallel vector present on `data_in`.
- `load_ready`  out  1: block can accept a vector this cycle.
- `data_in`  in  `data_width` × `size` (unpacked array `[size-1:0]`): parallel vector.
- `three_shift`  in  1: stride select, sampled with the load; 1 = stride 3, 0 = stride 1.
- `out_valid`  out  1: `out_data` holds a valid word.
- `out_ready`  in  1: downstream accepts the word this cycle.
- `out_data`  out  `data_width`: current serial word.
- `out_last`  out  1: current word is the final word of the vector.

## Operation
- States: IDLE and SHIFT. Reset enters IDLE.
- **IDLE**
  - `load_ready`=1, `out_valid`=0.
  - On `load_valid`: copy `data_in` into the internal array, latch `three_shift` as `stride` (1 or 3), set pointer to `size-1`, go to SHIFT.
- **SHIFT**
  - `out_valid`=1; `out_data` = array[pointer].
  - `out_last`=1 when `pointer - stride < 0`.
- **Beat accepted** (`out_valid & out_ready`)
  - Not last: pointer decrements by `stride`.
  - Last, and `load_valid`=0: return to IDLE.
- **Back-to-back load**
  - `load_ready` = IDLE, or (SHIFT & `out_ready` & `out_last`).
  - A load in the same cycle as the last beat is accepted: new vector captured, pointer reloaded to `size-1`, state stays SHIFT. No bubble between vectors.
- **Emission order**
  - Stride 1: indices `size-1`, `size-2`, …, 0. Exactly `size` beats.
  - Stride 3: indices `size-1`, `size-4`, … while ≥0. Exactly ceil(`size`/3) beats.
- **Pointer width:** signed, wide enough for −3 … `size-1`. Comparisons are signed.
- **Other loads ignored:** `load_valid` while `load_ready`=0 has no effect. The internal array and `stride` are unchanged.
- **Stride sampling:** `three_shift` matters only on an accepted load; mid-vector changes are ignored.
- **Reset mid-vector:** remaining words are discarded, nothing further is emitted, state goes to IDLE.

## Timing
- **Reset values (cycle after `reset`=1):**
  - `out_valid`=0, `out_last`=0, `out_data`=0, `load_ready`=1.
  - Internal array cleared to 0, pointer=0, `stride`=1.
- **Latency:** load accepted at edge N → first word valid on `out_data` after edge N, i.e. in cycle N+1.
- **Throughput:** one word per cycle while `out_ready`=1. Stride-1 vector occupies exactly `size` cycles.
- **Stall:** while `out_valid`=1 and `out_ready`=0, `out_data`, `out_last` and the pointer hold.
- **Registered signals:** `out_valid`, `out_data` and `out_last` are decoded only from registered state; none depends combinationally on `out_ready`.
- **Combinational path:** `load_ready` depends combinationally on `out_ready` (last-beat overlap only).
- **Size 1:** every vector is a single beat with `out_last`=1, in either stride.

## Test plan
- **Stride 1, basic** (`size`=3, width 32): load {d[2]=C, d[1]=B, d[0]=A}, `three_shift`=0, `out_ready`=1 → `out_data` = C, B, A on cycles N+1…N+3; `out_last` only with A; `out_valid`=0 at N+4.
- **Stride 3** (`size`=5): load words 0x10…0x14 at indices 0…4, `three_shift`=1 → 2 beats, 0x14 then 0x11 (`out_last`=1); index 0 is not emitted.
- **Backpressure:** hold `out_ready`=0 for 4 cycles after the first word → `out_data`=C held steady, `load_ready`=0, a competing load is ignored; release → B, A follow unchanged.
- **Back-to-back:** second vector {F,E,D} presented with `load_valid`=1 during A's accepted beat → D-vector accepted that cycle; output C,B,A,F,E,D on 6 consecutive cycles, no bubble.
- **Reset mid-vector:** assert `reset` after C is accepted → next cycle `out_valid`=0, `out_data`=0, `load_ready`=1; B and A are never emitted.
- **Round-trip:** feed the serial output into a `size`=3 shift register, one shift per accepted beat → after 3 beats, register word i equals original `data_in[i]` for all i.
